// File: rtl/data_change_fifo_if.sv
// Bus bundle between the data-change monitor FIFO and its driver/sink.
// Carries the monitored word, the sink handshake and the status outputs.
interface data_change_fifo_if #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] data_in_i;
    logic              clear_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic [CNT_W-1:0]  count_o;
    logic              overflow_o;
    logic [DROP_W-1:0] drop_cnt_o;

    modport master (
        output data_in_i, clear_i, ready_i,
        input  data_o, valid_o, count_o, overflow_o, drop_cnt_o
    );

    modport slave (
        input  data_in_i, clear_i, ready_i,
        output data_o, valid_o, count_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/data_change_fifo.sv
// Captures every change of a monitored bus into a small FIFO drained over
// valid/ready, with fill level, sticky overflow and a saturating drop count.
module data_change_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input logic              clk_i,
    input logic              reset_n_i,
    data_change_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] prev_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    logic chg, empty, full, push_req, push, pop, drop;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign chg      = (bus.data_in_i != prev_q);
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = !bus.clear_i && !empty && bus.ready_i;
    assign push_req = !bus.clear_i && chg;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_q   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            prev_q <= bus.data_in_i;
            if (bus.clear_i) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (drop) begin
                    overflow <= 1'b1;
                    drop_cnt <= sat_inc(drop_cnt);
                end
            end
        end
    end

    // Storage holds data only; emptiness is tracked by count, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= bus.data_in_i;
    end

    assign bus.data_o     = empty ? '0 : mem[rd_ptr];
    assign bus.valid_o    = !empty;
    assign bus.count_o    = count;
    assign bus.overflow_o = overflow;
    assign bus.drop_cnt_o = drop_cnt;
endmodule
